ei_axi4_slave_rd_resp: RTL and testbench
========================================

EI_AXI4_SLAVE_RD_RESP -- requirements
Module: ei_axi4_slave_rd_resp

Interface
REQ-001 Parameter ID_WIDTH, default 4, AR/R transaction ID width.
REQ-002 Parameter ADDR_WIDTH, default 32, araddr width; data width SHALL be fixed at 32 bits.
REQ-003 Parameter MEM_DEPTH, default 1024, number of 32-bit words in internal memory (power of 2).
REQ-004 aclk  in  1  single clock; all logic on rising edge.
REQ-005 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 arid  in  ID_WIDTH  read address ID.
REQ-007 araddr  in  ADDR_WIDTH  byte start address; bits [1:0] ignored.
REQ-008 arlen  in  8  beats minus one.
REQ-009 arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-010 arvalid  in  1  address valid.
REQ-011 arready  out  1  address ready.
REQ-012 rid  out  ID_WIDTH  echoes captured arid.
REQ-013 rdata  out  32  read data.
REQ-014 rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
REQ-015 rlast  out  1  final beat.
REQ-016 rvalid  out  1  read data valid.
REQ-017 rready  in  1  master accepts beat.
REQ-018 bd_we, bd_addr[log2(MEM_DEPTH)-1:0], bd_wdata[31:0]  in  backdoor word write, one word per cycle.

Function
REQ-019 FSM states IDLE, BURST; arready SHALL be 1 only in IDLE, one transaction outstanding, no AR/R overlap.
REQ-020 AR handshake (arvalid&arready) SHALL capture arid/araddr/arlen/arburst, move to BURST, drive first beat with rvalid=1 on the next cycle (1-cycle latency).
REQ-021 While rvalid=1 and rready=0, rid/rdata/rresp/rlast SHALL hold stable.
REQ-022 Each accepted beat (rvalid&rready) SHALL load the next beat in the same edge, giving one beat per cycle under continuous rready.
REQ-023 Beat addressing (word index): FIXED repeats start; INCR +1 per beat, no 4KB check; WRAP wraps within (arlen+1)-word aligned window.
REQ-024 rlast SHALL be 1 exactly on beat number arlen; arlen=0 gives single beat with rlast=1.
REQ-025 Acceptance of the rlast beat SHALL return to IDLE, arready=1 on the following cycle.
REQ-026 Word index >= MEM_DEPTH on a beat: rresp=DECERR, rdata=0 for that beat only.
REQ-027 arburst=11, or WRAP with arlen not in {1,3,7,15}: every beat rresp=SLVERR, rdata=0, full arlen+1 beats still issued.
REQ-028 Backdoor write to the address being loaded in the same cycle: beat SHALL return old data (read-before-write).

Reset
REQ-029 aresetn low, including mid-burst: state IDLE, arready=1, rvalid=0, rlast=0, rresp=00, rid=0, rdata=0; burst aborted.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-031 Macro EI_AXI4_RD_ERR_CHECK_EN defined: REQ-026/027 apply.
REQ-032 Macro undefined: rresp always OKAY, index taken modulo MEM_DEPTH, reserved burst treated as INCR, WRAP with illegal arlen treated as INCR.

Verification
REQ-033 Backdoor mem[0..3]=A0..A3; AR INCR addr 0x0 len 3 id 5, rready=1 -> beats A0..A3, rid=5, rlast on 4th, arready back 1 cycle after.
REQ-034 WRAP addr 0x8 len 3, mem[0..3]=10..13 -> rdata 12,13,10,11, all OKAY.
REQ-035 INCR len 1, rready low 3 cycles on beat 0 -> rdata/rid/rlast stable 4 cycles, then beat 1.
REQ-036 MEM_DEPTH=1024, INCR addr 0xFFC len 1 with macro -> beat0 OKAY mem[1023], beat1 DECERR rdata 0; without macro -> beat1 OKAY mem[0].
REQ-037 arburst=11 len 2 with macro -> 3 beats SLVERR rdata 0, rlast on 3rd.
REQ-038 aresetn low during beat 2 of len 7 -> rvalid 0 immediately, arready 1; new AR after release served with memory intact.

Source files
------------

// File: rtl/ei_axi4_slave_rd_resp_if.sv
// ei_axi4_slave_rd_resp_if: AXI4 read address/data channel bundle with master and slave views
interface ei_axi4_slave_rd_resp_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/ei_axi4_slave_rd_resp.sv
// ei_axi4_slave_rd_resp: AXI4 read-only slave over a backdoor-loaded word memory; EI_AXI4_RD_ERR_CHECK_EN enables DECERR/SLVERR responses
module ei_axi4_slave_rd_resp #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         i_aclk,
    input  logic                         i_aresetn,
    ei_axi4_slave_rd_resp_if.slave       io_axi,
    input  logic                         i_bd_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_bd_addr,
    input  logic [31:0]                  i_bd_wdata
);
    localparam int IW  = ADDR_WIDTH - 2;
    localparam int MAW = $clog2(MEM_DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          r_state, w_state_nxt;
    logic [ID_WIDTH-1:0] r_id;
    logic [IW-1:0]   r_idx;
    logic [7:0]      r_len, r_beat;
    logic [1:0]      r_mode;
    logic [31:0]     r_rdata;
    logic [1:0]      r_rresp;
    logic            r_rlast;
    logic [31:0]     r_mem [MEM_DEPTH];

    logic            w_hs, w_acc, w_load, w_wrap_ok;
    logic [1:0]      w_mode_in, w_ld_resp;
    logic [IW-1:0]   w_len_mask, w_nxt_idx, w_ld_idx;
    logic [7:0]      w_ld_beat, w_ld_len;
    logic [31:0]     w_mem_rd, w_ld_data;

    assign io_axi.arready = (r_state == IDLE);
    assign io_axi.rvalid  = (r_state == BURST);
    assign io_axi.rid     = r_id;
    assign io_axi.rdata   = r_rdata;
    assign io_axi.rresp   = r_rresp;
    assign io_axi.rlast   = r_rlast;

    assign w_hs      = io_axi.arvalid & io_axi.arready;
    assign w_acc     = io_axi.rvalid & io_axi.rready;
    assign w_load    = w_hs | (w_acc & ~r_rlast);
    assign w_wrap_ok = io_axi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15};

    // WRAP keeps the bits above the window size and increments only the bits inside it
    assign w_len_mask = IW'(r_len);
    assign w_nxt_idx  = (r_mode == 2'b00) ? r_idx :
                        (r_mode == 2'b10) ? ((r_idx & ~w_len_mask) | ((r_idx + 1'b1) & w_len_mask)) :
                        r_idx + 1'b1;

    // The beat being loaded is either the first of a new burst or the successor of the accepted one
    assign w_ld_idx  = w_hs ? IW'(io_axi.araddr >> 2) : w_nxt_idx;
    assign w_ld_beat = w_hs ? 8'd0 : r_beat + 8'd1;
    assign w_ld_len  = w_hs ? io_axi.arlen : r_len;
    assign w_mem_rd  = r_mem[w_ld_idx[MAW-1:0]];

`ifdef EI_AXI4_RD_ERR_CHECK_EN
    logic r_slv, w_ld_slv, w_dec;

    assign w_mode_in = io_axi.arburst;
    assign w_ld_slv  = w_hs ? ((io_axi.arburst == 2'b11) | ((io_axi.arburst == 2'b10) & ~w_wrap_ok)) : r_slv;
    assign w_dec     = (w_ld_idx >> MAW) != '0;
    assign w_ld_resp = w_ld_slv ? 2'b10 : w_dec ? 2'b11 : 2'b00;
    assign w_ld_data = (w_ld_slv | w_dec) ? 32'd0 : w_mem_rd;

    // Remember whether the whole burst is a slave error
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) r_slv <= 1'b0;
        else if (w_hs)  r_slv <= w_ld_slv;
    end
`else
    assign w_mode_in = ((io_axi.arburst == 2'b11) | ((io_axi.arburst == 2'b10) & ~w_wrap_ok)) ? 2'b01 : io_axi.arburst;
    assign w_ld_resp = 2'b00;
    assign w_ld_data = w_mem_rd;
`endif

    // State register
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    // Enter BURST on address handshake, leave after the last beat is accepted
    always_comb begin
        w_state_nxt = w_hs ? BURST : (w_acc & r_rlast) ? IDLE : r_state;
    end

    // Capture the request and load the next beat; held outputs stay stable under backpressure
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_id    <= '0;
            r_len   <= '0;
            r_mode  <= '0;
            r_idx   <= '0;
            r_beat  <= '0;
            r_rdata <= '0;
            r_rresp <= '0;
            r_rlast <= 1'b0;
        end else begin
            if (w_hs) begin
                r_id   <= io_axi.arid;
                r_len  <= io_axi.arlen;
                r_mode <= w_mode_in;
            end
            if (w_load) begin
                r_idx   <= w_ld_idx;
                r_beat  <= w_ld_beat;
                r_rdata <= w_ld_data;
                r_rresp <= w_ld_resp;
                r_rlast <= (w_ld_beat == w_ld_len);
            end else if (w_acc) begin
                r_rlast <= 1'b0;
            end
        end
    end

    // Backdoor word write; the beat loaded on the same edge still sees the old word
    always_ff @(posedge i_aclk) begin
        if (i_bd_we) r_mem[i_bd_addr] <= i_bd_wdata;
    end
endmodule

// File: tb/tb_ei_axi4_slave_rd_resp.sv
// tb_ei_axi4_slave_rd_resp: scoreboard bench for the AXI4 read slave
module tb_ei_axi4_slave_rd_resp;
    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [31:0] bd_wdata = '0;
    logic [31:0] mem_m [1024];
    beat_t       sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    ei_axi4_slave_rd_resp_if #(.ID_WIDTH(4), .ADDR_WIDTH(32)) axi ();

    ei_axi4_slave_rd_resp #(.ID_WIDTH(4), .ADDR_WIDTH(32), .MEM_DEPTH(1024)) dut (
        .i_aclk     (clk),
        .i_aresetn  (aresetn),
        .io_axi     (axi),
        .i_bd_we    (bd_we),
        .i_bd_addr  (bd_addr),
        .i_bd_wdata (bd_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic bd_write(input int a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = 10'(a); bd_wdata = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic push_exp(input logic [3:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst);
        longint start = longint'(addr >> 2);
        longint base, idx;
        int     n = len + 1;
        bit     ok = (len == 1 || len == 3 || len == 7 || len == 15);
        bit     slv = 1'b0;
        logic [1:0] mode = burst;
        beat_t  b;
`ifdef EI_AXI4_RD_ERR_CHECK_EN
        slv = (burst == 2'b11) || (burst == 2'b10 && !ok);
`else
        if (burst == 2'b11 || (burst == 2'b10 && !ok)) mode = 2'b01;
`endif
        base = start - (start % n);
        for (int i = 0; i <= len; i++) begin
            idx = (mode == 2'b00) ? start : (mode == 2'b10) ? base + ((start - base + i) % n) : start + i;
            b.id   = id;
            b.last = (i == len);
`ifdef EI_AXI4_RD_ERR_CHECK_EN
            b.resp = slv ? 2'b10 : (idx >= 1024) ? 2'b11 : 2'b00;
            b.data = (slv || idx >= 1024) ? 32'd0 : mem_m[int'(idx)];
`else
            b.resp = 2'b00;
            b.data = mem_m[int'(idx % 1024)];
`endif
            sb.push_back(b);
        end
    endtask

    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int stall, input bit bd_hit, input logic [31:0] bd_val);
        int st = stall;
        beat_t e;
        push_exp(id, addr, int'(len), burst);
        @(negedge clk);
        n_cmp++;
        if (axi.arready !== 1'b1) begin
            n_bad++; $display("FAIL arready_idle: got %b want 1", axi.arready);
        end
        axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arburst = burst; axi.arvalid = 1'b1;
        if (bd_hit) begin
            bd_we = 1'b1; bd_addr = addr[11:2]; bd_wdata = bd_val;
        end
        @(posedge clk);
        #1 axi.arvalid = 1'b0;
        bd_we = 1'b0;
        if (bd_hit) mem_m[addr[11:2]] = bd_val;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb[0];
            n_cmp++;
            if (axi.rvalid !== 1'b1) begin
                n_bad++; $display("FAIL rvalid_beat: got %b want 1", axi.rvalid);
                sb.delete();
                break;
            end
            n_cmp++;
            if ({axi.rid, axi.rdata, axi.rresp, axi.rlast} !== {e.id, e.data, e.resp, e.last}) begin
                n_bad++;
                $display("FAIL beat: got id=%h data=%h resp=%b last=%b want id=%h data=%h resp=%b last=%b",
                         axi.rid, axi.rdata, axi.rresp, axi.rlast, e.id, e.data, e.resp, e.last);
            end
            if (st > 0) begin
                axi.rready = 1'b0; st--;
            end else begin
                axi.rready = 1'b1; void'(sb.pop_front());
            end
        end
        @(negedge clk);
        axi.rready = 1'b0;
        n_cmp++;
        if ({axi.arready, axi.rvalid} !== 2'b10) begin
            n_bad++; $display("FAIL idle_after_last: got arready=%b rvalid=%b want arready=1 rvalid=0", axi.arready, axi.rvalid);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if ({axi.arready, axi.rvalid, axi.rlast, axi.rresp, axi.rid, axi.rdata} !== {1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_state: got arready=%b rvalid=%b rlast=%b rresp=%b rid=%h rdata=%h want 1 0 0 00 0 0",
                     axi.arready, axi.rvalid, axi.rlast, axi.rresp, axi.rid, axi.rdata);
        end
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    task automatic test_incr;
        for (int i = 0; i < 4; i++) bd_write(i, 32'hA0 + i);
        run_burst(4'd5, 32'h0, 8'd3, 2'b01, 0, 1'b0, 32'h0);
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 4; i++) bd_write(i, 32'h10 + i);
        run_burst(4'd2, 32'h8, 8'd3, 2'b10, 0, 1'b0, 32'h0);
        run_burst(4'd3, 32'h34, 8'd7, 2'b10, 0, 1'b0, 32'h0);
    endtask

    task automatic test_fixed;
        run_burst(4'd7, 32'h10, 8'd2, 2'b00, 0, 1'b0, 32'h0);
    endtask

    task automatic test_stall;
        run_burst(4'd9, 32'h20, 8'd1, 2'b01, 3, 1'b0, 32'h0);
    endtask

    task automatic test_boundary;
        bd_write(1023, 32'hCAFE_03FF);
        bd_write(0, 32'hCAFE_0000);
        run_burst(4'd1, 32'hFFC, 8'd1, 2'b01, 0, 1'b0, 32'h0);
    endtask

    task automatic test_reserved;
        run_burst(4'd4, 32'h40, 8'd2, 2'b11, 0, 1'b0, 32'h0);
        run_burst(4'd6, 32'h44, 8'd2, 2'b10, 0, 1'b0, 32'h0);
    endtask

    task automatic test_read_before_write;
        run_burst(4'd8, 32'h60, 8'd1, 2'b01, 0, 1'b1, 32'hDEAD_BEEF);
        run_burst(4'd8, 32'h60, 8'd0, 2'b01, 0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid;
        beat_t e;
        push_exp(4'd9, 32'h80, 7, 2'b01);
        @(negedge clk);
        axi.arid = 4'd9; axi.araddr = 32'h80; axi.arlen = 8'd7; axi.arburst = 2'b01; axi.arvalid = 1'b1;
        @(posedge clk);
        #1 axi.arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({axi.rvalid, axi.rid, axi.rdata, axi.rlast} !== {1'b1, e.id, e.data, e.last}) begin
                n_bad++;
                $display("FAIL pre_reset_beat: got v=%b id=%h data=%h last=%b want v=1 id=%h data=%h last=%b",
                         axi.rvalid, axi.rid, axi.rdata, axi.rlast, e.id, e.data, e.last);
            end
            axi.rready = (i < 2);
        end
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if ({axi.arready, axi.rvalid, axi.rlast, axi.rresp, axi.rid, axi.rdata} !== {1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 32'h0}) begin
            n_bad++;
            $display("FAIL mid_reset: got arready=%b rvalid=%b rlast=%b rresp=%b rid=%h rdata=%h want 1 0 0 00 0 0",
                     axi.arready, axi.rvalid, axi.rlast, axi.rresp, axi.rid, axi.rdata);
        end
        sb.delete();
        axi.rready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        run_burst(4'd3, 32'h80, 8'd7, 2'b01, 0, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back;
        int len;
        logic [1:0] bu;
        for (int k = 0; k < 8; k++) begin
            bu  = 2'($urandom_range(0, 2));
            len = (bu == 2'b10) ? (1 << $urandom_range(1, 4)) - 1 : $urandom_range(0, 9);
            run_burst(4'($urandom_range(0, 15)), 32'($urandom_range(0, 1000)) << 2, 8'(len), bu,
                      $urandom_range(0, 2), 1'b0, 32'h0);
        end
    endtask

    initial begin
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arburst = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        for (int i = 0; i < 1024; i++) bd_write(i, 32'h5A00_0000 ^ (i * 32'h0001_0203));
        test_reset();
        test_incr();
        test_wrap();
        test_fixed();
        test_stall();
        test_boundary();
        test_reserved();
        test_read_before_write();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
